// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage of the 16-bit RISC datapath.
// Owns the PC, addresses the combinational instruction ROM, and fills the
// IF/ID register. Handles stall, flush, branch/jump redirects and halts
// when the next PC would leave the program image or become misaligned.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_WORDS = 16,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [5:0]  branch_offset,
    input  logic [15:0] branch_pc_plus2,
    input  logic        jump,
    input  logic [12:0] jump_target,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    // Highest PC that still holds an instruction.
    localparam logic [15:0] LAST_PC = 16'(2 * IMEM_WORDS - 2);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pp2_q, pp2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic [15:0] seq_pc, br_pc, jmp_pc, target_pc;
    logic        load, bubble, capture, out_of_range;

    // Candidate next-PC values; all arithmetic wraps at 16 bits.
    assign seq_pc = pc_q + 16'd2;
    assign br_pc  = branch_pc_plus2 + {{9{branch_offset[5]}}, branch_offset, 1'b0};
    assign jmp_pc = {branch_pc_plus2[15:14], jump_target, 1'b0};

    // Next-state logic: redirect priority, range check and IF/ID update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pp2_d        = pp2_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        target_pc    = seq_pc;
        load         = 1'b0;
        bubble       = 1'b0;
        capture      = 1'b0;
        out_of_range = 1'b0;

        case (state_q)
            BOOT: begin
                // Settle cycle for the ROM: nothing fetched, PC untouched.
                state_d = RUN;
            end
            RUN: begin
                if (jump) begin
                    target_pc = jmp_pc;
                    load      = 1'b1;
                    bubble    = 1'b1;
                end else if (branch_taken) begin
                    target_pc = br_pc;
                    load      = 1'b1;
                    bubble    = 1'b1;
                end else if (flush) begin
                    load   = !stall;
                    bubble = 1'b1;
                end else if (!stall) begin
                    load    = 1'b1;
                    capture = 1'b1;
                end

                out_of_range = (target_pc > LAST_PC) || target_pc[0];

                // An illegal next PC stops fetch; the current fetch still lands.
                if (load && out_of_range) begin
                    state_d = HALT;
                end else if (load) begin
                    pc_d = target_pc;
                end

                if (bubble) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (capture) begin
                    instr_d = imem_instr;
                    pp2_d   = seq_pc;
                    valid_d = 1'b1;
                end
            end
            HALT: begin
                instr_d  = NOP_INSTR;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and registered outputs; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pp2_q    <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pp2_q    <= pp2_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_pc       = pc_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus2 = pp2_q;
    assign ifid_valid    = valid_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table of
// {inputs, expected outputs} followed by hand-written corner sequences.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken, jump;
    logic [5:0]  branch_offset;
    logic [15:0] branch_pc_plus2;
    logic [12:0] jump_target;
    logic [15:0] imem_pc, imem_instr, ifid_instr, ifid_pc_plus2;
    logic        ifid_valid, halted;

    logic [15:0] rom [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_pc[4:1]];

    instruction_fetch_unit #(
        .RESET_PC  (16'h0000),
        .IMEM_WORDS(16),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .branch_pc_plus2(branch_pc_plus2),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus2  (ifid_pc_plus2),
        .ifid_valid     (ifid_valid),
        .halted         (halted)
    );

    typedef struct {
        logic        rst, stall, flush, br, jmp;
        logic [5:0]  off;
        logic [15:0] bpp2;
        logic [12:0] jt;
        logic [15:0] e_pc, e_instr, e_pp2;
        logic        e_v, e_h;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, f, b, input logic [5:0] o,
                                input logic [15:0] bp, input logic j,
                                input logic [12:0] t, input logic [15:0] pc,
                                input logic [15:0] ins, input logic [15:0] pp,
                                input logic v, input logic h);
        vec_t x;
        x.rst = r; x.stall = s; x.flush = f; x.br = b; x.off = o; x.bpp2 = bp;
        x.jmp = j; x.jt = t; x.e_pc = pc; x.e_instr = ins; x.e_pp2 = pp;
        x.e_v = v; x.e_h = h;
        return x;
    endfunction

    task automatic cmp(input string tag, input string fld,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    // Drive on the falling edge, check just after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; stall = v.stall; flush = v.flush; branch_taken = v.br;
        branch_offset = v.off; branch_pc_plus2 = v.bpp2; jump = v.jmp;
        jump_target = v.jt;
        @(posedge clk);
        #1;
        cmp(tag, "imem_pc", imem_pc, v.e_pc);
        cmp(tag, "ifid_instr", ifid_instr, v.e_instr);
        cmp(tag, "ifid_pc_plus2", ifid_pc_plus2, v.e_pp2);
        cmp(tag, "ifid_valid", {15'd0, ifid_valid}, {15'd0, v.e_v});
        cmp(tag, "halted", {15'd0, halted}, {15'd0, v.e_h});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'(16'h1111 * (i + 1));
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_offset = 6'd0; branch_pc_plus2 = 16'd0; jump_target = 13'd0;

        //            rst stl fl br off    bpp2      j  jt     pc      instr     pp2      v  h
        tbl.push_back(mk(1, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0)); // reset
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0)); // boot
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd2,  16'h1111, 16'd2,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd4,  16'h2222, 16'd4,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd6,  16'h3333, 16'd6,  1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd6,  16'h3333, 16'd6,  1, 0)); // stall x3
        tbl.push_back(mk(0, 1, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd6,  16'h3333, 16'd6,  1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd6,  16'h3333, 16'd6,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd8,  16'h4444, 16'd8,  1, 0)); // resume at 6
        tbl.push_back(mk(0, 0, 0, 1, 6'h3E, 16'h0008, 0, 13'd0, 16'd4,  16'h0000, 16'd8,  0, 0)); // branch -2
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd6,  16'h3333, 16'd6,  1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6'h3E, 16'h0006, 1, 13'd5, 16'd10, 16'h0000, 16'd6,  0, 0)); // jump wins
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd12, 16'h6666, 16'd12, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd14, 16'h0000, 16'd12, 0, 0)); // flush
        tbl.push_back(mk(0, 1, 1, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd14, 16'h0000, 16'd12, 0, 0)); // flush+stall
        tbl.push_back(mk(0, 1, 0, 1, 6'h03, 16'h0010, 0, 13'd0, 16'd22, 16'h0000, 16'd12, 0, 0)); // branch over stall
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd24, 16'hCCCC, 16'd24, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd26, 16'hDDDD, 16'd26, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd28, 16'hEEEE, 16'd28, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd30, 16'hFFFF, 16'd30, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd30, 16'h1110, 16'd32, 1, 0)); // last word
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd30, 16'h0000, 16'd32, 0, 1)); // halted
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 1, 13'd1, 16'd30, 16'h0000, 16'd32, 0, 1)); // jump ignored
        tbl.push_back(mk(1, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0)); // reset exits HALT
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd2,  16'h1111, 16'd2,  1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0)); // reset over stall+flush
        tbl.push_back(mk(0, 1, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0)); // boot
        tbl.push_back(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd2,  16'h1111, 16'd2,  1, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Misaligned branch target: bubble now, PC frozen, halted next cycle.
        apply(mk(0, 0, 0, 1, 6'h00, 16'h0005, 0, 13'd0, 16'd2, 16'h0000, 16'd2, 0, 0), "misalign");
        apply(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd2, 16'h0000, 16'd2, 0, 1), "misalign_halt");
        // Reset with a jump pending, then a jump whose upper bits leave the image.
        apply(mk(1, 0, 0, 0, 6'h00, 16'h0000, 1, 13'd3, 16'd0, 16'h0000, 16'd0, 0, 0), "rst_jump");
        apply(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0, 16'h0000, 16'd0, 0, 0), "rst_boot");
        apply(mk(0, 0, 0, 0, 6'h00, 16'hC000, 1, 13'd1, 16'd0, 16'h0000, 16'd0, 0, 0), "far_jump");
        apply(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0, 16'h0000, 16'd0, 0, 1), "far_jump_halt");
        // In-range jump with zero upper bits redirects with one bubble.
        apply(mk(1, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0), "rst2");
        apply(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd0,  16'h0000, 16'd0,  0, 0), "boot2");
        apply(mk(0, 0, 0, 0, 6'h00, 16'h0002, 1, 13'd7, 16'd14, 16'h0000, 16'd0,  0, 0), "jump14");
        apply(mk(0, 0, 0, 0, 6'h00, 16'h0000, 0, 13'd0, 16'd16, 16'h8888, 16'd16, 1, 0), "after_jump");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the instruction memory in the 16-bit RISC datapath.
- Owns the program counter and drives `imem_pc` to the instruction ROM, which is combinational and word-indexed by pc[4:1].
- Captures the returned instruction into the IF/ID pipeline register with a valid bit.
- Applies stall, flush, branch and jump redirects from later stages, and halts on running off the end of the program.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
IMEM_WORDS, 16, number of 16-bit words in instruction memory; the last legal PC is 2*IMEM_WORDS-2.
NOP_INSTR, 16'h0000, instruction placed in IF/ID on bubble, flush or halt.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hazard stall from decode; hold PC and IF/ID
flush  input  1  squash the IF/ID contents (insert bubble)
branch_taken  input  1  taken branch resolved in execute
branch_offset  input  6  signed word offset, relative to the branch's PC+2
branch_pc_plus2  input  16  PC+2 of the branch instruction
jump  input  1  unconditional jump request
jump_target  input  13  word target for the jump
imem_pc  output  16  address to instruction memory (= pc register)
imem_instr  input  16  instruction returned combinationally for imem_pc
ifid_instr  output  16  registered instruction
ifid_pc_plus2  output  16  registered PC+2 of ifid_instr
ifid_valid  output  1  ifid_instr is a real instruction
halted  output  1  sticky; fetch stopped, PC out of range

Behaviour:
- Reset (sync, rst=1 at edge):
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0, halted=0.
  - FSM goes to BOOT.
  - rst overrides every other input, including mid-redirect or in HALT.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle, no capture (ifid_valid stays 0); pc unchanged; next state RUN. This gives the memory one settle cycle after reset.
  - RUN: normal fetch, following the per-cycle priority below.
  - HALT: pc frozen, ifid_instr=NOP_INSTR, ifid_valid=0, halted=1. Only rst exits HALT.
- Next-PC arithmetic is 16-bit unsigned; overflow wraps modulo 2^16.
  - seq = pc+2.
  - br = branch_pc_plus2 + (sign-extended branch_offset << 1).
  - jmp = {branch_pc_plus2[15:14], jump_target, 1'b0}, i.e. the upper bits are taken from the redirecting instruction's PC+2.
- Per-cycle priority in RUN, highest first:
  1. jump=1: pc<=jmp; IF/ID<=NOP, valid=0. Stall is ignored.
  2. branch_taken=1: pc<=br; IF/ID<=NOP, valid=0. Stall is ignored.
  3. flush=1 (no redirect): pc<=seq unless stall=1; IF/ID<=NOP, valid=0.
  4. stall=1: pc and all IF/ID fields hold.
  5. Otherwise: pc<=seq; ifid_instr<=imem_instr; ifid_pc_plus2<=seq; valid=1.
- Simultaneous jump and branch_taken: jump wins.
- Redirect latency: the redirected target appears on imem_pc the cycle after the request edge; exactly one bubble is emitted.
- Range check, evaluated in RUN on the PC about to be loaded:
  - If the new pc > 2*IMEM_WORDS-2, or the new pc is odd (misaligned), go to HALT instead of loading.
  - The instruction at the last legal address is still captured normally.
- Throughput: one instruction per cycle with no stalls or redirects.

Test Plan:
- Reset then free-run with ROM words 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444:
  - imem_pc sequence after reset: 0, 0 (BOOT), 2, 4, ...
  - ifid_instr 16'h1111 with valid=1 appears on the 2nd edge after BOOT; ifid_pc_plus2=2.
- Stall held 3 cycles at pc=6:
  - imem_pc stays 6; ifid_instr/ifid_pc_plus2/valid unchanged for 3 cycles.
  - Resume fetches 6 next.
- branch_taken with branch_pc_plus2=8, offset=6'b111110 (-2):
  - next imem_pc=4; one bubble (valid=0, ifid_instr=NOP_INSTR).
  - The following cycle captures the word at 4.
- jump and branch_taken together, jump_target=13'd5, branch_pc_plus2=16'h0006:
  - imem_pc=10; the branch is ignored; one bubble.
- Run to pc=30 (IMEM_WORDS=16):
  - word 15 captured with valid=1; the next cycle halted=1, valid=0, imem_pc stays 30.
  - rst returns pc to 0 and clears halted.
- Sync reset asserted during a stall with flush high:
  - all outputs take their reset values at that edge; BOOT, then RUN from RESET_PC.
